// File: rtl/hangman_pkg.sv
// Shared constants, state encoding and letter-code helper for the Hangman round logic.
package hangman_pkg;

    localparam int LETTER_W    = 5;
    localparam int NUM_LETTERS = 26;
    localparam int WORD_LEN    = 5;

    localparam logic [LETTER_W-1:0] LETTER_NONE = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_UPDATE  = 3'd2,
        S_RELEASE = 3'd3,
        S_WIN     = 3'd4,
        S_LOSE    = 3'd5
    } state_t;

    function automatic logic is_valid_letter(input logic [LETTER_W-1:0] code);
        return (code < 5'd26);
    endfunction

endpackage

// File: rtl/hangman_guess_ctrl.sv
// Hangman round controller: captures a guess, scans the five word positions one per cycle,
// then updates found flags, miss bookkeeping and the sticky win/lose result.
module hangman_guess_ctrl
    import hangman_pkg::*;
#(
    parameter int MAX_MISS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [4:0] guess,
    input  logic [4:0] letter1,
    input  logic [4:0] letter2,
    input  logic [4:0] letter3,
    input  logic [4:0] letter4,
    input  logic [4:0] letter5,
    output logic [4:0] found,
    output logic [2:0] miss_count,
    output logic       busy,
    output logic       guess_done,
    output logic       last_hit,
    output logic       last_repeat,
    output logic       win,
    output logic       lose
);

    localparam logic [2:0] MAX_MISS_C = 3'(MAX_MISS);

    state_t                 state_r;
    logic [2:0]             idx_r;
    logic [LETTER_W-1:0]    guess_r;
    logic                   hit_any_r;
    logic                   match_any_r;
    logic                   invalid_r;
    logic [NUM_LETTERS-1:0] miss_mask_r;

    logic [LETTER_W-1:0]    letter_sel_s;
    logic [WORD_LEN-1:0]    idx_onehot_s;
    logic [WORD_LEN-1:0]    unused_s;
    logic [31:0]            mask_ext_s;
    logic [31:0]            guess_onehot_s;
    logic                   match_s;
    logic                   mask_hit_s;
    logic                   new_miss_s;
    logic                   repeat_s;
    logic [2:0]             miss_next_s;
    logic                   win_s;
    logic                   lose_s;

    // Position mux, miss-mask lookup and end-of-guess decisions.
    always_comb begin
        letter_sel_s = LETTER_NONE;
        case (idx_r)
            3'd0:    letter_sel_s = letter1;
            3'd1:    letter_sel_s = letter2;
            3'd2:    letter_sel_s = letter3;
            3'd3:    letter_sel_s = letter4;
            3'd4:    letter_sel_s = letter5;
            default: letter_sel_s = LETTER_NONE;
        endcase
        idx_onehot_s   = 5'b00001 << idx_r;
        unused_s       = {letter5 == LETTER_NONE, letter4 == LETTER_NONE, letter3 == LETTER_NONE,
                          letter2 == LETTER_NONE, letter1 == LETTER_NONE};
        match_s        = (letter_sel_s == guess_r) && (letter_sel_s != LETTER_NONE);
        // Padding to 32 bits keeps the lookup in range for the invalid codes 26..31.
        mask_ext_s     = {6'b000000, miss_mask_r};
        guess_onehot_s = 32'd1 << guess_r;
        mask_hit_s     = mask_ext_s[guess_r];
        new_miss_s     = !invalid_r && !match_any_r && !mask_hit_s;
        repeat_s       = !invalid_r && ((!match_any_r && mask_hit_s) || (match_any_r && !hit_any_r));
        if (new_miss_s && (miss_count < MAX_MISS_C)) begin
            miss_next_s = miss_count + 3'd1;
        end else begin
            miss_next_s = miss_count;
        end
        win_s  = &(found | unused_s);
        lose_s = (miss_next_s == MAX_MISS_C);
    end

    // Round FSM together with all datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            idx_r       <= 3'd0;
            guess_r     <= 5'd0;
            hit_any_r   <= 1'b0;
            match_any_r <= 1'b0;
            invalid_r   <= 1'b0;
            miss_mask_r <= 26'd0;
            found       <= 5'd0;
            miss_count  <= 3'd0;
            busy        <= 1'b0;
            guess_done  <= 1'b0;
            last_hit    <= 1'b0;
            last_repeat <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    guess_done <= 1'b0;
                    if (go) begin
                        guess_r     <= guess;
                        idx_r       <= 3'd0;
                        hit_any_r   <= 1'b0;
                        match_any_r <= 1'b0;
                        busy        <= 1'b1;
                        if (is_valid_letter(guess)) begin
                            invalid_r <= 1'b0;
                            state_r   <= S_CHECK;
                        end else begin
                            invalid_r <= 1'b1;
                            state_r   <= S_UPDATE;
                        end
                    end
                end
                S_CHECK: begin
                    if (match_s) begin
                        match_any_r <= 1'b1;
                        if ((found & idx_onehot_s) == 5'd0) begin
                            found     <= found | idx_onehot_s;
                            hit_any_r <= 1'b1;
                        end
                    end
                    if (idx_r == 3'd4) begin
                        state_r <= S_UPDATE;
                    end else begin
                        idx_r <= idx_r + 3'd1;
                    end
                end
                S_UPDATE: begin
                    busy       <= 1'b0;
                    guess_done <= 1'b1;
                    // An invalid code leaves the hit/repeat history untouched.
                    if (!invalid_r) begin
                        last_hit    <= hit_any_r;
                        last_repeat <= repeat_s;
                    end
                    if (new_miss_s) begin
                        miss_mask_r <= miss_mask_r | guess_onehot_s[NUM_LETTERS-1:0];
                    end
                    miss_count <= miss_next_s;
                    if (win_s) begin
                        win     <= 1'b1;
                        state_r <= S_WIN;
                    end else if (lose_s) begin
                        lose    <= 1'b1;
                        state_r <= S_LOSE;
                    end else begin
                        state_r <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    guess_done <= 1'b0;
                    if (!go) begin
                        state_r <= S_IDLE;
                    end
                end
                S_WIN, S_LOSE: begin
                    guess_done <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
